nibble_serial_adder_ctrl: RTL and testbench

Sequential controller that reuses one 4-bit ripple-carry adder slice to add or subtract two multi-nibble operands, one nibble per clock, least-significant nibble first. It latches operands on a start pulse and feeds the adder slice with nibble-sliced operands and the registered carry. It assembles the result word and reports carry and signed overflow with a one-cycle done pulse. It sits between a simple requester (FSM or testbench) and the existing `four_bit_adder` datapath.

---
 rtl/nibble_serial_adder_ctrl_pkg.sv | 9 +
 rtl/nibble_serial_adder_ctrl_adder.sv | 16 +
 rtl/nibble_serial_adder_ctrl.sv | 70 +++++++
 tb/tb_nibble_serial_adder_ctrl.sv | 138 +++++++++++++
 4 files changed

// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// nibble_serial_adder_ctrl_pkg: shared state encoding and nibble width
package nibble_serial_adder_ctrl_pkg;
  localparam int NIB_W = 4;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/nibble_serial_adder_ctrl_adder.sv
// four_bit_adder: combinational 4-bit ripple-carry slice
module four_bit_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [4:0] c;
  assign c[0] = ci;
  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign co = c[4];
endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl: nibble-serial add/subtract through one shared 4-bit adder slice
module nibble_serial_adder_ctrl
  import nibble_serial_adder_ctrl_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     sub,
  input  logic [NIB_W*NIBBLES-1:0] a,
  input  logic [NIB_W*NIBBLES-1:0] b,
  output logic                     busy,
  output logic                     done,
  output logic [NIB_W*NIBBLES-1:0] s,
  output logic                     co,
  output logic                     ovf
);
  localparam int W  = NIB_W * NIBBLES;
  localparam int IW = $clog2(NIBBLES);
  state_t state, state_nx;
  logic [W-1:0] a_r, b_r, s_r, s_nx;
  logic [IW-1:0] idx;
  logic carry_r, c_out, last;
  logic [NIB_W-1:0] a_n, b_n, sum;
  assign a_n  = a_r[NIB_W*idx +: NIB_W];
  assign b_n  = b_r[NIB_W*idx +: NIB_W];
  assign last = idx == IW'(NIBBLES - 1);
  assign busy = state == RUN;
  assign done = state == DONE;
  four_bit_adder u_add (.a(a_n), .b(b_n), .ci(carry_r), .s(sum), .co(c_out));
  always_comb begin
    s_nx = s_r;
    s_nx[NIB_W*idx +: NIB_W] = sum;
    state_nx = state == IDLE ? (start ? RUN : IDLE) :
               state == RUN  ? (last ? DONE : RUN) : IDLE;
  end
  // Visible results load on the final RUN edge so they are valid during the done cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      carry_r <= 1'b0;
      a_r     <= '0;
      b_r     <= '0;
      s_r     <= '0;
      s       <= '0;
      co      <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        a_r     <= a;
        b_r     <= sub ? ~b : b;
        carry_r <= sub;
        idx     <= '0;
      end
      if (state == RUN) begin
        s_r     <= s_nx;
        carry_r <= c_out;
        idx     <= idx + 1'b1;
        if (last) begin
          s   <= s_nx;
          co  <= c_out;
          ovf <= (a_r[W-1] == b_r[W-1]) && (s_nx[W-1] != a_r[W-1]);
        end
      end
    end
  end
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// tb_nibble_serial_adder_ctrl: directed self-checking bench for the nibble-serial adder
module tb_nibble_serial_adder_ctrl;
  logic clk = 1'b0;
  logic rst, start, sub;
  logic [15:0] a, b, s;
  logic busy, done, co, ovf;
  int n_chk = 0;
  int n_fail = 0;

  nibble_serial_adder_ctrl #(.NIBBLES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .s(s), .co(co), .ovf(ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_done(output int lat, output int bc);
    lat = 0;
    bc = 0;
    while (!done && lat < 10) begin
      if (busy) bc++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                        input logic ts, input logic [15:0] es, input logic ec, input logic eo);
    int lat, bc;
    @(negedge clk);
    a = ta; b = tb_v; sub = ts; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat, bc);
    check({tag, " latency"}, lat, 4);
    check({tag, " busy_cycles"}, bc, 4);
    check({tag, " s"}, s, es);
    check({tag, " co"}, co, ec);
    check({tag, " ovf"}, ovf, eo);
    check({tag, " busy_in_done"}, busy, 0);
    @(posedge clk); #1;
    check({tag, " done_one_cycle"}, done, 0);
    check({tag, " s_held"}, s, es);
  endtask

  initial begin
    int lat, bc, nd, last_d;
    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset s", s, 0);
    check("reset co", co, 0);
    check("reset ovf", ovf, 0);
    @(negedge clk) rst = 1'b0;

    run_op("add_basic", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    run_op("add_carry", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("sub_borrow", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub_ovf",   16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // start pulsed mid-RUN must be ignored
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    a = 16'hAAAA; b = 16'h5555; sub = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat, bc);
    check("ignore_start done", done, 1);
    check("ignore_start s", s, 16'h3333);
    check("ignore_start co", co, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("ignore_start no_requeue", busy, 0);

    // reset in the middle of RUN, with start held alongside it
    @(negedge clk);
    a = 16'h0F0F; b = 16'h0101; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    check("abort busy", busy, 0);
    check("abort s", s, 0);
    check("abort co", co, 0);
    nd = 0;
    for (int i = 0; i < 8; i++) begin
      if (done || busy) nd++;
      @(posedge clk); #1;
    end
    check("abort no_done", nd, 0);
    run_op("after_abort", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

    // continuous start: one operation every NIBBLES+2 cycles
    @(negedge clk);
    a = 16'h00FF; b = 16'h0001; sub = 1'b0; start = 1'b1;
    nd = 0;
    last_d = -1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done) begin
        nd++;
        check("stream s", s, 16'h0100);
        check("stream busy_in_done", busy, 0);
        if (last_d >= 0) check("stream period", i - last_d, 6);
        else check("stream first_latency", i, 4);
        last_d = i;
      end
    end
    start = 1'b0;
    check("stream done_count", nd, 3);
    repeat (8) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
